// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler wrapped around an external 4:1 mux: arbitrates four sources,
// drives the mux select and buffers the selected word behind a valid/ready output.
module mux4_rr_sched #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  output logic [3:0]   ack,
  output logic [1:0]   sel,
  input  logic [N-1:0] mux_y,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_src
);

  typedef enum logic [1:0] {IDLE, SEL, CAP, HOLD} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_sel;
  logic [1:0]   r_last;
  logic [1:0]   r_src;
  logic [3:0]   r_ack;
  logic [N-1:0] r_data;
  logic         r_valid;

  logic [1:0]   w_grant;
  logic         w_any_req;
  logic         w_load_sel;
  logic         w_capture;
  logic         w_release;

  // Scan (last+1), (last+2), ... so the most recently served source ranks lowest.
  function automatic logic [1:0] rr_pick(input logic [3:0] rq, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && rq[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_grant   = rr_pick(req, r_last);
  assign w_any_req = |req;

  always_comb begin
    w_state_nxt = r_state;
    w_load_sel  = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_load_sel  = 1'b1;
          w_state_nxt = SEL;
        end
      end
      SEL: begin
        // A source that withdrew while the mux settled forfeits its grant.
        if (req[r_sel]) begin
          w_capture   = 1'b1;
          w_state_nxt = CAP;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CAP: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          w_release = 1'b1;
          if (w_any_req) begin
            w_load_sel  = 1'b1;
            w_state_nxt = SEL;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_src   <= 2'd0;
      r_ack   <= 4'b0000;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_capture ? (4'b0001 << r_sel) : 4'b0000;
      if (w_load_sel) begin
        r_sel <= w_grant;
      end
      if (w_capture) begin
        r_data  <= mux_y;
        r_src   <= r_sel;
        r_valid <= 1'b1;
        r_last  <= r_sel;
      end else if (w_release) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ack       = r_ack;
  assign sel       = r_sel;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_src   = r_src;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched; the companion mux is modelled with fixed inputs
// i0..i3 = 0001, 0010, 0100, 1000.
module tb_mux4_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic [1:0] sel;
  logic [3:0] mux_y;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_src;

  int checks = 0;
  int errors = 0;

  mux4_rr_sched #(.N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .sel      (sel),
    .mux_y    (mux_y),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_src  (out_src)
  );

  always_comb begin
    mux_y = 4'b0000;
    case (sel)
      2'd0: mux_y = 4'b0001;
      2'd1: mux_y = 4'b0010;
      2'd2: mux_y = 4'b0100;
      2'd3: mux_y = 4'b1000;
      default: mux_y = 4'b0000;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cap(input string tag, input logic [3:0] d, input logic [1:0] s);
    chk({tag, "_data"}, 8'(out_data), 8'(d));
    chk({tag, "_src"}, 8'(out_src), 8'(s));
    chk({tag, "_ack"}, 8'(ack), 8'(4'b0001 << s));
    chk({tag, "_valid"}, 8'(out_valid), 8'd1);
  endtask

  initial begin
    logic [3:0] words [5];
    logic [1:0] srcs  [5];
    words = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    srcs  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // T1 reset with all requests high
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t1_valid", 8'(out_valid), 8'd0);
      chk("t1_ack", 8'(ack), 8'd0);
      chk("t1_sel", 8'(sel), 8'd0);
    end
    chk("t1_data", 8'(out_data), 8'd0);
    rst_n = 1'b1; req = 4'b0000;
    step();
    chk("idle_valid", 8'(out_valid), 8'd0);

    // T2 single request from channel 2
    req = 4'b0100;
    step();
    chk("t2_sel", 8'(sel), 8'd2);
    chk("t2_valid_early", 8'(out_valid), 8'd0);
    step();
    chk_cap("t2", 4'b0100, 2'd2);
    req = 4'b0000;
    step();
    chk("t2_ack_one_cycle", 8'(ack), 8'd0);
    chk("t2_hold_valid", 8'(out_valid), 8'd1);
    step();
    chk("t2_released", 8'(out_valid), 8'd0);

    // T3 round-robin from a fresh reset
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1; req = 4'b1111; out_ready = 1'b1;
    step();
    chk("t3_sel0", 8'(sel), 8'd0);
    step();
    for (int w = 0; w < 5; w++) begin
      chk_cap($sformatf("t3_w%0d", w), words[w], srcs[w]);
      if (w < 4) begin
        step();
        chk($sformatf("t3_hold_ack%0d", w), 8'(ack), 8'd0);
        chk($sformatf("t3_hold_valid%0d", w), 8'(out_valid), 8'd1);
        step();
        chk($sformatf("t3_gap_valid%0d", w), 8'(out_valid), 8'd0);
        chk($sformatf("t3_next_sel%0d", w), 8'(sel), 8'(srcs[w+1]));
        step();
      end
    end

    // T4 backpressure after the last round-robin capture
    out_ready = 1'b0; req = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_data", 8'(out_data), 8'b0001);
      chk("t4_valid", 8'(out_valid), 8'd1);
      chk("t4_ack", 8'(ack), 8'd0);
    end
    out_ready = 1'b1; req = 4'b0010;
    step();
    chk("t4_release_valid", 8'(out_valid), 8'd0);
    chk("t4_next_sel", 8'(sel), 8'd1);
    step();
    chk_cap("t4_next", 4'b0010, 2'd1);
    req = 4'b0000;
    step();
    step();
    chk("t4_idle_valid", 8'(out_valid), 8'd0);

    // T5 withdraw in SEL: last stays at 1, so 0011 grants channel 0
    req = 4'b0100;
    step();
    chk("t5_sel", 8'(sel), 8'd2);
    req = 4'b0000;
    step();
    chk("t5_no_ack", 8'(ack), 8'd0);
    chk("t5_no_valid", 8'(out_valid), 8'd0);
    step();
    chk("t5_idle_ack", 8'(ack), 8'd0);
    chk("t5_idle_valid", 8'(out_valid), 8'd0);
    req = 4'b0011;
    step();
    chk("t5_regrant_sel", 8'(sel), 8'd0);
    step();
    chk_cap("t5_regrant", 4'b0001, 2'd0);

    // T6 reset while holding a word
    req = 4'b0000; out_ready = 1'b0;
    step();
    chk("t6_hold_valid", 8'(out_valid), 8'd1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_valid", 8'(out_valid), 8'd0);
    chk("t6_rst_ack", 8'(ack), 8'd0);
    chk("t6_rst_data", 8'(out_data), 8'd0);
    chk("t6_rst_sel", 8'(sel), 8'd0);
    rst_n = 1'b1; req = 4'b1111; out_ready = 1'b1;
    step();
    chk("t6_sel", 8'(sel), 8'd0);
    step();
    chk_cap("t6", 4'b0001, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
